// File: rtl/imm_pkg.sv
// -----------------------------------------------------------------------------
// imm_pkg
// Shared definitions for the decode-stage immediate generator:
//   - immediate format encodings (FMT_I .. FMT_ILL)
//   - base/RV64 opcode constants used by the automatic format decoder
//   - skid-buffer occupancy state type
//   - opcode -> format decode helper used by the top level
// -----------------------------------------------------------------------------
package imm_pkg;

  // Immediate format encodings carried on ImmFmt
  localparam logic [2:0] FMT_I   = 3'b000;
  localparam logic [2:0] FMT_S   = 3'b001;
  localparam logic [2:0] FMT_B   = 3'b010;
  localparam logic [2:0] FMT_U   = 3'b011;
  localparam logic [2:0] FMT_J   = 3'b100;
  localparam logic [2:0] FMT_Z   = 3'b101;
  localparam logic [2:0] FMT_RSV = 3'b110;
  localparam logic [2:0] FMT_ILL = 3'b111;

  // Opcodes recognised by the automatic decoder
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Occupancy of the output register / skid register pair
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } buf_state_t;

  // Resolve the immediate format from the opcode. SYSTEM instructions use
  // funct3[2] (Instr[14]) to tell the CSR-immediate forms from the rest.
  function automatic logic [2:0] decode_fmt(input logic [6:0] opcode,
                                            input logic       f3_msb);
    logic [2:0] fmt;
    case (opcode)
      OPC_OP_IMM,
      OPC_LOAD,
      OPC_JALR,
      OPC_OP_IMM32: fmt = FMT_I;
      OPC_STORE:    fmt = FMT_S;
      OPC_BRANCH:   fmt = FMT_B;
      OPC_LUI,
      OPC_AUIPC:    fmt = FMT_U;
      OPC_JAL:      fmt = FMT_J;
      OPC_SYSTEM:   fmt = f3_msb ? FMT_Z : FMT_I;
      default:      fmt = FMT_ILL;
    endcase
    return fmt;
  endfunction

  // Both reserved encodings (110, 111) are unresolvable
  function automatic logic fmt_is_illegal(input logic [2:0] fmt);
    return (fmt[2] & fmt[1]);
  endfunction

endpackage

// File: rtl/imm_extract.sv
// -----------------------------------------------------------------------------
// imm_extract
// Combinational immediate extraction. Assembles the 32-bit immediate for the
// selected format and extends it to XLEN: signed formats replicate Instr[31],
// the CSR-immediate format (Z) is zero-extended, reserved formats give 0 and
// raise o_illegal.
//
// Ports
//   i_instr   [31:0]      instruction word
//   i_fmt     [2:0]       resolved immediate format
//   o_imm     [XLEN-1:0]  extended immediate
//   o_illegal             format is reserved/unresolvable
// -----------------------------------------------------------------------------
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  input  logic [2:0]      i_fmt,
  output logic [XLEN-1:0] o_imm,
  output logic            o_illegal
);

  logic [31:0] w_raw;
  logic        w_sign;
  logic        w_unused_opcode;

  // The opcode field never contributes to an immediate
  assign w_unused_opcode = ^i_instr[6:0];

  // Build the low 32 bits and pick the extension bit for the upper part
  always_comb begin
    w_raw     = 32'd0;
    w_sign    = 1'b0;
    o_illegal = 1'b0;
    case (i_fmt)
      FMT_I: begin
        w_raw  = {{20{i_instr[31]}}, i_instr[31:20]};
        w_sign = i_instr[31];
      end
      FMT_S: begin
        w_raw  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
        w_sign = i_instr[31];
      end
      FMT_B: begin
        w_raw  = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                  i_instr[30:25], i_instr[11:8], 1'b0};
        w_sign = i_instr[31];
      end
      FMT_U: begin
        // U keeps its 32-bit value but is still sign-extended on RV64
        w_raw  = {i_instr[31:12], 12'h000};
        w_sign = i_instr[31];
      end
      FMT_J: begin
        w_raw  = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                  i_instr[20], i_instr[30:21], 1'b0};
        w_sign = i_instr[31];
      end
      FMT_Z: begin
        w_raw  = {27'd0, i_instr[19:15]};
        w_sign = 1'b0;
      end
      default: begin
        w_raw     = 32'd0;
        w_sign    = 1'b0;
        o_illegal = 1'b1;
      end
    endcase
  end

  // Extend to XLEN: fill with the extension bit, then overlay the low word
  always_comb begin
    o_imm       = {XLEN{w_sign}};
    o_imm[31:0] = w_raw;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
// Registered decode-stage immediate generator with a valid/ready output and a
// 2-entry skid buffer (output register + skid register).
//
// Parameters
//   XLEN         immediate width, 32 or 64
//   AUTO_DECODE  1: format from the Instr opcode, 0: format from ImmSrc
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_valid   Instr/ImmSrc valid
//   in_ready   block can accept (skid register empty); reads 1 during reset
//   Instr      instruction word
//   ImmSrc     explicit format select (unused when AUTO_DECODE=1)
//   flush      discard every buffered entry; drops a same-cycle input
//   out_valid  Imm_ext/ImmFmt/Illegal valid
//   out_ready  consumer accepts the output entry
//   Imm_ext    extended immediate (0 when Illegal)
//   ImmFmt     resolved format of the output entry
//   Illegal    format unresolvable
// -----------------------------------------------------------------------------
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit AUTO_DECODE = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     Instr,
  input  logic [2:0]      ImmSrc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Imm_ext,
  output logic [2:0]      ImmFmt,
  output logic            Illegal
);

  // Input-side decode
  logic [2:0]      w_fmt;
  logic [XLEN-1:0] w_imm;
  logic            w_ill;
  logic            w_ill_fmt;
  logic            w_accept;

  // Buffer control
  buf_state_t      r_state;
  buf_state_t      w_state_nxt;
  logic            w_load_out_in;
  logic            w_load_out_skid;
  logic            w_load_skid;

  // Registered outputs and skid payload
  logic            r_out_valid;
  logic            r_skid_full;
  logic [XLEN-1:0] r_imm;
  logic [2:0]      r_fmt;
  logic            r_ill;
  logic [XLEN-1:0] r_skid_imm;
  logic [2:0]      r_skid_fmt;
  logic            r_skid_ill;

  // Resolve the immediate format from the opcode or the explicit select
  always_comb begin
    w_fmt = FMT_I;
    if (AUTO_DECODE) begin
      w_fmt = decode_fmt(Instr[6:0], Instr[14]);
    end else begin
      w_fmt = ImmSrc;
    end
  end

  imm_extract #(
    .XLEN (XLEN)
  ) u_extract (
    .i_instr   (Instr),
    .i_fmt     (w_fmt),
    .o_imm     (w_imm),
    .o_illegal (w_ill)
  );

  // Cross-check of the extractor's flag against the format encoding; both
  // must agree, the OR keeps the flag set if either path reports it
  assign w_ill_fmt = fmt_is_illegal(w_fmt) | w_ill;

  // The skid register being empty is the only acceptance condition; flush
  // drops a coincident input
  assign w_accept = in_valid & ~r_skid_full & ~flush;

  // Next-state and payload-move decisions for the two-entry buffer
  always_comb begin
    w_state_nxt     = r_state;
    w_load_out_in   = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_state_nxt   = ONE;
          w_load_out_in = 1'b1;
        end else begin
          w_state_nxt = EMPTY;
        end
      end
      ONE: begin
        if (w_accept && out_ready) begin
          w_state_nxt   = ONE;
          w_load_out_in = 1'b1;
        end else if (w_accept) begin
          // Consumer stalled: park the new entry behind the output register
          w_state_nxt = TWO;
          w_load_skid = 1'b1;
        end else if (out_ready) begin
          w_state_nxt = EMPTY;
        end else begin
          w_state_nxt = ONE;
        end
      end
      TWO: begin
        if (out_ready) begin
          w_state_nxt     = ONE;
          w_load_out_skid = 1'b1;
        end else begin
          w_state_nxt = TWO;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase

    // Flush overrides every transition and payload move
    if (flush) begin
      w_state_nxt     = EMPTY;
      w_load_out_in   = 1'b0;
      w_load_out_skid = 1'b0;
      w_load_skid     = 1'b0;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // Buffer state plus the registered valid/full flags derived from it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_out_valid <= 1'b0;
      r_skid_full <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != EMPTY);
      r_skid_full <= (w_state_nxt == TWO);
    end
  end

  // Output register: loads from the input side or drains the skid register,
  // otherwise holds so the payload is stable under backpressure
  always_ff @(posedge clk) begin
    if (reset) begin
      r_imm <= {XLEN{1'b0}};
      r_fmt <= FMT_I;
      r_ill <= 1'b0;
    end else if (w_load_out_in) begin
      r_imm <= w_ill_fmt ? {XLEN{1'b0}} : w_imm;
      r_fmt <= w_fmt;
      r_ill <= w_ill_fmt;
    end else if (w_load_out_skid) begin
      r_imm <= r_skid_imm;
      r_fmt <= r_skid_fmt;
      r_ill <= r_skid_ill;
    end else begin
      r_imm <= r_imm;
      r_fmt <= r_fmt;
      r_ill <= r_ill;
    end
  end

  // Skid register: captures an entry that arrives while the output stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      r_skid_imm <= {XLEN{1'b0}};
      r_skid_fmt <= FMT_I;
      r_skid_ill <= 1'b0;
    end else if (w_load_skid) begin
      r_skid_imm <= w_ill_fmt ? {XLEN{1'b0}} : w_imm;
      r_skid_fmt <= w_fmt;
      r_skid_ill <= w_ill_fmt;
    end else begin
      r_skid_imm <= r_skid_imm;
      r_skid_fmt <= r_skid_fmt;
      r_skid_ill <= r_skid_ill;
    end
  end

  // in_ready follows the registered skid flag; forced high while reset is
  // asserted (the handshake itself is ignored by the reset branch above)
  assign in_ready  = reset | ~r_skid_full;
  assign out_valid = r_out_valid;
  assign Imm_ext   = r_imm;
  assign ImmFmt    = r_fmt;
  assign Illegal   = r_ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe. Two instances share one stimulus
// stream: XLEN=32 with opcode decode, and XLEN=64 with explicit ImmSrc.
// A queue-based scoreboard predicts every output entry from the format rules.
module tb_imm_gen_pipe;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic [31:0] Instr;
  logic [2:0]  ImmSrc;

  logic        rdy32, ov32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic        rdy64, ov64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q32[$];
  exp_t q64[$];

  logic [6:0] opcs [10] = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23,
                            7'h63, 7'h37, 7'h17, 7'h6F, 7'h73};

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b1)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
    .Instr(Instr), .ImmSrc(ImmSrc), .flush(flush), .out_valid(ov32),
    .out_ready(out_ready), .Imm_ext(imm32), .ImmFmt(fmt32), .Illegal(ill32));

  imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b0)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64),
    .Instr(Instr), .ImmSrc(ImmSrc), .flush(flush), .out_valid(ov64),
    .out_ready(out_ready), .Imm_ext(imm64), .ImmFmt(fmt64), .Illegal(ill64));

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: immediate value as a signed integer built from the fields
  function automatic exp_t ref_model(input logic [31:0] ins, input logic [2:0] src,
                                     input bit auto_d, input int xlen);
    exp_t        e;
    longint      v;
    logic [2:0]  f;
    logic [63:0] r;
    if (auto_d) begin
      case (ins[6:0])
        7'h13, 7'h03, 7'h67, 7'h1B: f = 3'd0;
        7'h23:                      f = 3'd1;
        7'h63:                      f = 3'd2;
        7'h37, 7'h17:               f = 3'd3;
        7'h6F:                      f = 3'd4;
        7'h73:                      f = ins[14] ? 3'd5 : 3'd0;
        default:                    f = 3'd7;
      endcase
    end else begin
      f = src;
    end
    v = 0;
    case (f)
      3'd0: begin v = ins[31:20]; if (ins[31]) v = v - 4096; end
      3'd1: begin v = ins[31:25] * 32 + ins[11:7]; if (ins[31]) v = v - 4096; end
      3'd2: begin
        v = ins[31] * 4096 + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2;
        if (ins[31]) v = v - 8192;
      end
      3'd3: begin v = ins[31:12] * 4096; if (ins[31]) v = v - (longint'(1) << 32); end
      3'd4: begin
        v = ins[31] * (1 << 20) + ins[19:12] * 4096 + ins[20] * 2048 + ins[30:21] * 2;
        if (ins[31]) v = v - (1 << 21);
      end
      3'd5: v = ins[19:15];
      default: v = 0;
    endcase
    r = v;
    if (xlen == 32) r[63:32] = 32'd0;
    e.ill = (f >= 3'd6);
    e.fmt = f;
    e.imm = e.ill ? 64'd0 : r;
    return e;
  endfunction

  // Scoreboard for the 32-bit instance
  always @(negedge clk) begin
    if (reset) begin
      q32.delete();
    end else begin
      check_val("valid32", ov32, (q32.size() != 0) ? 1 : 0);
      check_val("ready32", rdy32, (q32.size() < 2) ? 1 : 0);
      if (ov32 && q32.size() != 0) begin
        check_val("imm32", imm32, q32[0].imm);
        check_val("fmt32", fmt32, q32[0].fmt);
        check_val("ill32", ill32, q32[0].ill);
      end
      if (flush) begin
        q32.delete();
      end else begin
        if (ov32 && out_ready && q32.size() != 0) void'(q32.pop_front());
        if (in_valid && rdy32) q32.push_back(ref_model(Instr, ImmSrc, 1'b1, 32));
      end
    end
  end

  // Scoreboard for the 64-bit instance
  always @(negedge clk) begin
    if (reset) begin
      q64.delete();
    end else begin
      check_val("valid64", ov64, (q64.size() != 0) ? 1 : 0);
      check_val("ready64", rdy64, (q64.size() < 2) ? 1 : 0);
      if (ov64 && q64.size() != 0) begin
        check_val("imm64", imm64, q64[0].imm);
        check_val("fmt64", fmt64, q64[0].fmt);
        check_val("ill64", ill64, q64[0].ill);
      end
      if (flush) begin
        q64.delete();
      end else begin
        if (ov64 && out_ready && q64.size() != 0) void'(q64.pop_front());
        if (in_valid && rdy64) q64.push_back(ref_model(Instr, ImmSrc, 1'b0, 64));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] words [7] = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3, 32'h123452B7,
                             32'h0010006F, 32'h0052D073, 32'h00000000};
  logic [31:0] exp_w [7] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000,
                             32'h00000800, 32'h00000005, 32'h00000000};
  logic [2:0]  srcs  [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
  logic [2:0]  fmts  [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    Instr = 32'd0; ImmSrc = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_valid32", ov32, 0);
    check_val("rst_imm32", imm32, 0);
    check_val("rst_fmt32", fmt32, 0);
    check_val("rst_ill32", ill32, 0);
    check_val("rst_ready32", rdy32, 1);
    check_val("rst_valid64", ov64, 0);
    check_val("rst_imm64", imm64, 0);
    step();
    reset = 1'b0;

    // Back-to-back stream with the consumer always ready
    for (int k = 0; k < 7; k++) begin
      Instr = words[k]; ImmSrc = srcs[k]; in_valid = 1'b1;
      if (k > 0) begin
        @(negedge clk);
        check_val("b2b_valid", ov32, 1);
        check_val("b2b_imm", imm32, exp_w[k-1]);
        check_val("b2b_fmt", fmt32, fmts[k-1]);
        if (k == 1) check_val("b2b_imm64_addi", imm64, 64'hFFFFFFFFFFFFFFFF);
      end
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check_val("illegal_flag", ill32, 1);
    check_val("illegal_imm", imm32, 0);
    check_val("illegal_fmt", fmt32, 7);
    step();

    // Backpressure: two words fill the buffer
    out_ready = 1'b0;
    Instr = 32'h123452B7; ImmSrc = 3'd3; in_valid = 1'b1;
    step();
    Instr = 32'hFFF00093; ImmSrc = 3'd0;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check_val("bp_ready", rdy32, 0);
    check_val("bp_hold0", imm32, 32'h12345000);
    step();
    @(negedge clk);
    check_val("bp_hold1", imm32, 32'h12345000);
    step();
    out_ready = 1'b1;
    step();
    @(negedge clk);
    check_val("bp_second", imm32, 32'hFFFFFFFF);
    check_val("bp_ready_back", rdy32, 1);
    step();
    @(negedge clk);
    check_val("bp_drained", ov32, 0);
    step();

    // Flush while full with a coincident input
    out_ready = 1'b0;
    Instr = 32'hFE20AE23; ImmSrc = 3'd1; in_valid = 1'b1;
    step();
    Instr = 32'h0010006F; ImmSrc = 3'd4;
    step();
    flush = 1'b1; Instr = 32'h123452B7; ImmSrc = 3'd3;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check_val("flush_valid32", ov32, 0);
    check_val("flush_valid64", ov64, 0);
    repeat (3) step();

    // Reset in the middle of a full buffer
    out_ready = 1'b0;
    Instr = 32'hFFF00093; ImmSrc = 3'd0; in_valid = 1'b1;
    step();
    Instr = 32'hFE000CE3; ImmSrc = 3'd2;
    step();
    reset = 1'b1;
    @(negedge clk);
    check_val("rst_mid_ready32", rdy32, 1);
    check_val("rst_mid_ready64", rdy64, 1);
    step();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check_val("rst_mid_valid64", ov64, 0);
    check_val("rst_mid_imm64", imm64, 0);
    check_val("rst_mid_fmt64", fmt64, 0);
    check_val("rst_mid_ill64", ill64, 0);
    check_val("rst_mid_valid32", ov32, 0);
    step();

    // Randomised traffic against the scoreboards
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom % 400) == 0;
      flush     = ($urandom % 24) == 0;
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 10) < 7;
      Instr     = $urandom;
      if (($urandom % 12) < 10) Instr[6:0] = opcs[$urandom % 10];
      ImmSrc    = 3'($urandom % 8);
      step();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, registered immediate generator for the decode stage. Takes a 32-bit instruction word and derives the immediate format from the opcode (AUTO_DECODE=1) or from an explicit ImmSrc select. Returns the sign- or zero-extended immediate at XLEN width through a valid/ready output backed by a 2-entry skid buffer. Sits between the fetch/decode register and the execute-stage operand mux, and adds full-rate backpressure, flush and illegal-format reporting.

## Interface
- XLEN, 32, immediate output width; legal values 32 or 64.
- AUTO_DECODE, 1, 1 = format from Instr opcode; 0 = format from ImmSrc.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  Instr/ImmSrc valid.
- in_ready  output  1  block can accept; equals !skid_full.
- Instr  input  32  instruction word; bits [6:0] opcode.
- ImmSrc  input  3  explicit format select; ignored when AUTO_DECODE=1.
- flush  input  1  discard all buffered entries.
- out_valid  output  1  Imm_ext/ImmFmt/Illegal valid.
- out_ready  input  1  consumer accepts output.
- Imm_ext  output  XLEN  extended immediate.
- ImmFmt  output  3  resolved format of the output entry.
- Illegal  output  1  format unresolvable; Imm_ext forced to 0.

## Operation
- Format encodings:
  - 000 I: {sext, Instr[31:20]}.
  - 001 S: {sext, Instr[31:25], Instr[11:7]}.
  - 010 B: {sext, Instr[31], Instr[7], Instr[30:25], Instr[11:8], 0}.
  - 011 U: {sext, Instr[31:12], 12'b0}. The U value is sign-extended from bit 31 when XLEN=64.
  - 100 J: {sext, Instr[31], Instr[19:12], Instr[20], Instr[30:21], 0}.
  - 101 Z: zero-extended Instr[19:15] (CSR immediate).
  - 110/111: Illegal=1, Imm_ext=0.
- Sign extension always replicates Instr[31] up to XLEN-1.
- Auto decode by opcode:
  - I: 0010011, 0000011, 1100111, 0011011.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - 1110011: Z if Instr[14]=1, else I.
  - Any other opcode: format 111 (illegal).
- Buffer states:
  - EMPTY: out_valid=0.
  - ONE: output register full.
  - TWO: output register and skid register both full.
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept + out_ready → ONE (new data).
  - ONE + accept + !out_ready → TWO (new data into skid).
  - ONE + !accept + out_ready → EMPTY.
  - TWO + out_ready → ONE (skid moves to output).
  - TWO + !out_ready → TWO.
- accept = in_valid && in_ready && !flush.
- Ordering is strictly FIFO; no entry is dropped or duplicated except by flush.

## Timing
- Latency: 1 cycle from accepted input to out_valid.
- Throughput: 1 per cycle while out_ready stays high.
- in_ready is driven from a register: it deasserts the cycle after the block enters TWO and reasserts the cycle after it leaves TWO.
- Output payload stays stable while out_valid && !out_ready.
- flush: next state EMPTY; out_valid=0 the following cycle. A simultaneous in_valid is dropped. Flush takes priority over out_ready.
- reset: state EMPTY, out_valid=0, Imm_ext=0, ImmFmt=000, Illegal=0, skid cleared. in_ready reads 1 while reset is high, but handshakes during reset are ignored. Reset mid-transfer discards both entries.
- reset has priority over flush; flush has priority over accept.

## Structure
- Package imm_pkg holds:
  - format localparams (FMT_I … FMT_ILL);
  - opcode constants;
  - buffer state enum {EMPTY, ONE, TWO}.
- Sub-module imm_extract (combinational, parameter XLEN). Inputs Instr and format; outputs Imm_ext and Illegal. Instantiated once, on the input side before the output register.
- Top level holds the format decode, the output register, the skid register and the state FSM.

## Test plan
- XLEN=32, AUTO: Instr 0xFFF00093 (addi -1) → next cycle out_valid=1, Imm_ext 0xFFFFFFFF, ImmFmt 000.
- Back-to-back, out_ready=1:
  - 0xFE20AE23 → 0xFFFFFFFC / S;
  - 0xFE000CE3 → 0xFFFFFFF8 / B;
  - 0x123452B7 → 0x12345000 / U;
  - 0x0010006F → 0x00000800 / J;
  - one output per cycle, in order.
- Backpressure: out_ready=0 and push 2 words → in_ready=0 from the following cycle, first output held stable; raise out_ready → both words emerge in order, in_ready=1 one cycle later.
- flush with state TWO and in_valid=1 → next cycle out_valid=0; the flushed words never appear.
- CSR/illegal: 0x0052D073 (csrrwi, rs1=5) → Imm 0x5, ImmFmt 101. Instr 0x00000000 → Illegal=1, Imm_ext 0, ImmFmt 111.
- XLEN=64, AUTO_DECODE=0:
  - ImmSrc 000 with 0xFFF00093 → 0xFFFFFFFFFFFFFFFF.
  - reset asserted mid-stream → all outputs at reset values the next cycle.
